// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter that applies one 1-bit step per clock.
//
// A start request captures mode and amt, then walks q through max(amt,1)
// clock cycles, shifting or rotating by one bit each cycle. A request with
// amt == 0 still takes one cycle but leaves q and shift_out untouched.
// Requests are accepted only while not busy (IDLE or DONE). If load and
// start are both high when accepted, load wins.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   load      : load din into q when accepted
//   din       : parallel load data [WIDTH]
//   start     : begin an operation of amt single-bit steps
//   mode      : 00 LSL, 01 LSR, 10 ASR (sign fill), 11 ROR
//   amt       : step count [AMT_W], unsigned
//   q         : registered data value [WIDTH]
//   busy      : operation in progress, requests ignored
//   done      : one-cycle completion pulse
//   shift_out : last bit shifted or rotated out of q
module seq_shifter #(
  parameter int              WIDTH = 8,
  parameter int              AMT_W = 4,
  parameter logic [WIDTH-1:0] INIT = 'h66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             shift_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_LSL = 2'b00,
    M_LSR = 2'b01,
    M_ASR = 2'b10,
    M_ROR = 2'b11
  } mode_t;

  state_t           state, state_nx;
  mode_t            mode_r, mode_nx;
  logic [AMT_W-1:0] cnt, cnt_nx;
  logic             zero_r, zero_nx;   // captured amt was 0: count a cycle, no step
  logic [WIDTH-1:0] q_r, q_nx;
  logic             so_r, so_nx;

  // single-bit step of the current q under the captured mode
  logic [WIDTH-1:0] q_step;
  logic             step_out;

  always_comb begin
    q_step   = q_r;
    step_out = 1'b0;
    unique case (mode_r)
      M_LSL: begin
        q_step   = {q_r[WIDTH-2:0], 1'b0};
        step_out = q_r[WIDTH-1];
      end
      M_LSR: begin
        q_step   = {1'b0, q_r[WIDTH-1:1]};
        step_out = q_r[0];
      end
      M_ASR: begin
        q_step   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        step_out = q_r[0];
      end
      M_ROR: begin
        q_step   = {q_r[0], q_r[WIDTH-1:1]};
        step_out = q_r[0];
      end
      default: begin
        q_step   = q_r;
        step_out = so_r;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    mode_nx  = mode_r;
    cnt_nx   = cnt;
    zero_nx  = zero_r;
    q_nx     = q_r;
    so_nx    = so_r;
    unique case (state)
      S_IDLE, S_DONE: begin
        // DONE falls back to IDLE unless a new request chains straight on
        state_nx = S_IDLE;
        if (load) begin
          q_nx = din;
        end else if (start) begin
          mode_nx  = mode_t'(mode);
          zero_nx  = (amt == '0);
          cnt_nx   = (amt == '0) ? AMT_W'(1) : amt;
          state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!zero_r) begin
          q_nx  = q_step;
          so_nx = step_out;
        end
        cnt_nx = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1))
          state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode_r <= M_LSL;
      cnt    <= '0;
      zero_r <= 1'b0;
      q_r    <= INIT;
      so_r   <= 1'b0;
    end else begin
      state  <= state_nx;
      mode_r <= mode_nx;
      cnt    <= cnt_nx;
      zero_r <= zero_nx;
      q_r    <= q_nx;
      so_r   <= so_nx;
    end
  end

  // status is a pure decode of the state register, so it only moves on clk
  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign q         = q_r;
  assign shift_out = so_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=8, AMT_W=4, INIT=8'h66).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] din;
  logic       start;
  logic [1:0] mode;
  logic [3:0] amt;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       shift_out;

  int total = 0;
  int bad   = 0;

  seq_shifter #(.WIDTH(8), .AMT_W(4), .INIT(8'h66)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .din       (din),
    .start     (start),
    .mode      (mode),
    .amt       (amt),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expect q/busy/done/shift_out together
  task automatic st(input string tag, input logic [7:0] eq, input logic eb,
                    input logic ed, input logic es);
    chk({tag, ".q"},    32'(q),         32'(eq));
    chk({tag, ".busy"}, 32'(busy),      32'(eb));
    chk({tag, ".done"}, 32'(done),      32'(ed));
    chk({tag, ".so"},   32'(shift_out), 32'(es));
  endtask

  task automatic go(input logic [1:0] m, input logic [3:0] a);
    start = 1'b1; mode = m; amt = a;
    tick();
    start = 1'b0;
  endtask

  task automatic ld(input logic [7:0] d);
    load = 1'b1; din = d;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int nb;
    int k;
    rst_n = 1'b0; load = 1'b0; din = '0; start = 1'b0; mode = '0; amt = '0;

    // reset held two cycles
    tick(); tick();
    st("rst", 8'h66, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    st("idle_hold", 8'h66, 0, 0, 0);

    // LSL by 2 from 0x66
    go(2'b00, 4'd2);
    st("lsl.e0", 8'h66, 1, 0, 0);
    tick(); st("lsl.e1", 8'hCC, 1, 0, 0);
    tick(); st("lsl.e2", 8'h98, 0, 1, 1);
    tick(); st("lsl.idle", 8'h98, 0, 0, 1);

    // ASR by 3 from 0x81
    ld(8'h81);
    st("ld81", 8'h81, 0, 0, 1);
    go(2'b10, 4'd3);
    tick(); st("asr.e1", 8'hC0, 1, 0, 1);
    tick(); st("asr.e2", 8'hE0, 1, 0, 0);
    tick(); st("asr.e3", 8'hF0, 0, 1, 0);
    tick(); st("asr.idle", 8'hF0, 0, 0, 0);

    // ROR by 9 from 0x01; mid-op input changes and a request pulse are ignored
    ld(8'h01);
    go(2'b11, 4'd9);
    mode = 2'b00; amt = 4'd1;
    nb = 0;
    while (busy && nb < 30) begin
      nb++;
      if (nb == 4) begin start = 1'b1; load = 1'b1; din = 8'hFF; end
      tick();
      start = 1'b0; load = 1'b0;
    end
    chk("ror.busy_cycles", 32'(nb), 32'd9);
    st("ror.end", 8'h80, 0, 1, 1);

    // back-to-back: start accepted in DONE
    go(2'b01, 4'd1);
    st("b2b.e0", 8'h80, 1, 0, 1);
    tick(); st("b2b.e1", 8'h40, 0, 1, 0);
    tick(); st("b2b.idle", 8'h40, 0, 0, 0);

    // amt beyond width: ASR by 12 from 0x80 saturates to sign bits
    ld(8'h80);
    go(2'b10, 4'd12);
    k = 0;
    while (!done && k < 40) begin tick(); k++; end
    chk("asr12.wait_done", 32'(done), 32'd1);
    chk("asr12.cycles", 32'(k), 32'd12);
    chk("asr12.q", 32'(q), 32'hFF);
    chk("asr12.so", 32'(shift_out), 32'd1);

    // amt = 0 from reset value
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    go(2'b00, 4'd0);
    st("amt0.e0", 8'h66, 1, 0, 0);
    tick(); st("amt0.e1", 8'h66, 0, 1, 0);
    tick(); st("amt0.idle", 8'h66, 0, 0, 0);

    // load and start together: load only
    load = 1'b1; start = 1'b1; din = 8'h3C; mode = 2'b00; amt = 4'd2;
    tick();
    load = 1'b0; start = 1'b0;
    st("ldst.e0", 8'h3C, 0, 0, 0);
    tick(); st("ldst.e1", 8'h3C, 0, 0, 0);

    // reset aborts LSR by 5 after two steps
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    go(2'b01, 4'd5);
    tick(); st("abort.s1", 8'h33, 1, 0, 0);
    tick(); st("abort.s2", 8'h19, 1, 0, 1);
    rst_n = 1'b0;
    tick(); st("abort.rst", 8'h66, 0, 0, 0);
    rst_n = 1'b1;
    tick(); st("abort.after", 8'h66, 0, 0, 0);
    tick(); st("abort.after2", 8'h66, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data register width in bits; legal range WIDTH >= 2.
REQ-002 Parameter AMT_W, default 4: width of shift-amount input; legal range AMT_W >= 1.
REQ-003 Parameter INIT, default 8'h66 (WIDTH bits): value loaded into q on reset.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1: one clock; reset is synchronous and active-low.
REQ-006 Port load  input  1: load din into q when accepted.
REQ-007 Port din  input  WIDTH: parallel load data.
REQ-008 Port start  input  1: request an operation of amt single-bit shifts.
REQ-009 Port mode  input  2: 00 LSL, 01 LSR, 10 ASR (sign-fill), 11 ROR (rotate right).
REQ-010 Port amt  input  AMT_W: requested shift count, unsigned, 0..2^AMT_W-1.
REQ-011 Port q  output  WIDTH: registered data value.
REQ-012 Port busy  output  1: operation in progress; new requests ignored.
REQ-013 Port done  output  1: one-cycle pulse marking operation completion.
REQ-014 Port shift_out  output  1: registered copy of the last bit shifted or rotated out of q.

Function
REQ-015 FSM states IDLE, SHIFT, DONE; load/start accepted only in IDLE or DONE.
REQ-016 Accepted load: q <= din at that edge; state -> IDLE; busy, done = 0 next cycle.
REQ-017 load and start high together when accepted: load wins, start dropped, no operation begun.
REQ-018 Accepted start at edge E0: capture mode and amt into internal registers; remaining count n = max(amt,1); state -> SHIFT; busy = 1 from E0.
REQ-019 In SHIFT, each edge performs one 1-bit step on q per captured mode (only when amt != 0) and decrements count; captured mode/amt are not affected by input changes.
REQ-020 LSL: q <= {q[WIDTH-2:0],0}, shift_out <= q[WIDTH-1].
REQ-021 LSR: q <= {0,q[WIDTH-1:1]}, shift_out <= q[0].
REQ-022 ASR: q <= {q[WIDTH-1],q[WIDTH-1:1]}, shift_out <= q[0].
REQ-023 ROR: q <= {q[0],q[WIDTH-1:1]}, shift_out <= q[0].
REQ-024 At edge En (count reaches 0): state -> DONE, busy = 0, done = 1 for exactly one cycle; q holds final value from En.
REQ-025 amt = 0: q and shift_out unchanged; busy high one cycle (E0..E1); done high cycle after E1.
REQ-026 amt >= WIDTH: stepping continues for all amt cycles; LSL/LSR yield 0, ASR yields all sign bits, ROR yields rotate by amt mod WIDTH.
REQ-027 DONE with no accepted request returns to IDLE next edge; start accepted in DONE gives back-to-back operation with done low in the following cycle.
REQ-028 load or start during SHIFT are ignored with no effect on q, count or captured mode.
REQ-029 q, shift_out hold value in IDLE and DONE when no request is accepted.

Reset
REQ-030 rst_n = 0 at any rising edge: q <= INIT, shift_out <= 0, busy <= 0, done <= 0, state <= IDLE, count cleared.
REQ-031 Reset has priority over load/start and aborts an operation in progress with no done pulse.
REQ-032 No output changes except on rising clk edge; no asynchronous reset path.

Verification (WIDTH=8, AMT_W=4, INIT=8'h66)
REQ-033 rst_n low 2 cycles -> q=0x66, busy=0, done=0, shift_out=0.
REQ-034 start, mode=00, amt=2 from 0x66 -> q 0xCC then 0x98; busy 2 cycles; done 1 cycle after E2; shift_out=1.
REQ-035 load din=0x81, then start mode=10, amt=3 -> q 0xC0, 0xE0, 0xF0; shift_out=0; done single pulse.
REQ-036 load 0x01, start mode=11, amt=9 -> busy 9 cycles, final q=0x80, shift_out=1; start pulse mid-operation ignored.
REQ-037 start amt=0 -> q unchanged 0x66, busy 1 cycle, done next cycle; load+start same cycle -> only load effective.
REQ-038 start mode=01, amt=5 from 0x66, rst_n low after 2 shifts -> q=0x66, busy=0, no done pulse.
